accum_frame_mc: RTL and testbench

// Multi-channel frame accumulator. Sums unsigned samples per channel (channel on din_tuser) until

---
 rtl/accum_frame_mc_pkg.sv | 33 +++
 rtl/accum_frame_mc_if.sv | 30 +++
 rtl/accum_frame_mc_out_fifo.sv | 48 ++++
 rtl/accum_frame_mc.sv | 137 +++++++++++++
 tb/tb_accum_frame_mc.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accum_frame_mc_pkg.sv
// rtl/accum_frame_mc_pkg.sv - shared constants, width derivations and FIFO entry type
package accum_frame_mc_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int p = 1; p < value; p = p * 2) begin
            r++;
        end
        return r;
    endfunction

    localparam int DATAWIDTH_IN  = 32;
    localparam int DATAWIDTH_OUT = 8;
    localparam int NUM_CH        = 4;
    localparam int MAX_FRAME     = 1024;
    localparam int OUT_DEPTH     = 4;
    localparam int SHIFT_W       = 6;

    // Accumulator holds a full frame of max-size samples without wrapping.
    localparam int ACC_W = DATAWIDTH_IN + clog2(MAX_FRAME);
    localparam int CNT_W = clog2(MAX_FRAME) + 1;
    localparam int CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int PTR_W = clog2(OUT_DEPTH);

    typedef struct packed {
        logic [DATAWIDTH_OUT-1:0] dout;
        logic [CH_W-1:0]          tuser;
        logic [CNT_W-1:0]         cnt;
        logic                     sat;
    } entry_t;

endpackage

// File: rtl/accum_frame_mc_if.sv
// rtl/accum_frame_mc_if.sv - sample input, result output and config bundle
interface accum_frame_mc_if;
    import accum_frame_mc_pkg::*;

    logic [DATAWIDTH_IN-1:0]  din;
    logic                     din_tvalid;
    logic                     din_tready;
    logic                     din_tlast;
    logic [CH_W-1:0]          din_tuser;
    logic [SHIFT_W-1:0]       cfg_shift;
    logic [DATAWIDTH_OUT-1:0] cfg_min;
    logic                     soft_clr;
    logic [DATAWIDTH_OUT-1:0] dout;
    logic                     dout_tvalid;
    logic                     dout_tready;
    logic [CH_W-1:0]          dout_tuser;
    logic [CNT_W-1:0]         dout_cnt;
    logic                     dout_sat;

    modport slave (
        input  din, din_tvalid, din_tlast, din_tuser, cfg_shift, cfg_min, soft_clr, dout_tready,
        output din_tready, dout, dout_tvalid, dout_tuser, dout_cnt, dout_sat
    );

    modport master (
        output din, din_tvalid, din_tlast, din_tuser, cfg_shift, cfg_min, soft_clr, dout_tready,
        input  din_tready, dout, dout_tvalid, dout_tuser, dout_cnt, dout_sat
    );

endinterface

// File: rtl/accum_frame_mc_out_fifo.sv
// rtl/accum_frame_mc_out_fifo.sv - result queue, OUT_DEPTH entries, head visible combinationally
module accum_frame_mc_out_fifo
    import accum_frame_mc_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  entry_t         wdata,
    input  logic           pop,
    output entry_t         rdata,
    output logic [PTR_W:0] count
);

    entry_t           mem [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(OUT_DEPTH));
    // A pop frees the slot in the same cycle, so a push into a full queue is allowed alongside it.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; memory cleared so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/accum_frame_mc.sv
// rtl/accum_frame_mc.sv - multi-channel frame accumulator with scale, clamp and output queue
module accum_frame_mc
    import accum_frame_mc_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    accum_frame_mc_if.slave bus
);

    logic [ACC_W-1:0] acc [NUM_CH];
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [NUM_CH-1:0] ovf;

    logic [CH_W-1:0]  ch;
    logic             ch_ok;
    logic             accept;
    logic             frame_done;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] sum_sat;
    logic [CNT_W-1:0] beats;

    logic             sc_valid;
    logic [ACC_W-1:0] sc_sum;
    logic [CH_W-1:0]  sc_ch;
    logic [CNT_W-1:0] sc_cnt;
    logic             sc_sat;
    logic [ACC_W-1:0] shifted;
    logic             clip;
    logic [DATAWIDTH_OUT-1:0] out_val;
    entry_t           wentry;
    entry_t           rentry;
    logic [PTR_W:0]   fifo_count;
    logic             pop;
    logic [PTR_W+1:0] occ_next;

    assign ch         = bus.din_tuser;
    assign ch_ok      = 32'(ch) < NUM_CH;
    assign accept     = bus.din_tvalid & bus.din_tready;
    assign frame_done = accept & bus.din_tlast & ch_ok & ~bus.soft_clr;
    assign sum_ext    = {1'b0, acc[ch]} + (ACC_W+1)'(bus.din);
    assign carry      = sum_ext[ACC_W];
    assign sum_sat    = (carry | ovf[ch]) ? '1 : sum_ext[ACC_W-1:0];
    assign beats      = (cnt[ch] == '1) ? cnt[ch] : cnt[ch] + 1'b1;

    // Per-channel partial sums; a tlast beat hands its total to the scale stage and restarts the channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else if (bus.soft_clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else if (accept && ch_ok) begin
            if (bus.din_tlast) begin
                acc[ch] <= '0;
                cnt[ch] <= '0;
                ovf[ch] <= 1'b0;
            end else begin
                acc[ch] <= sum_sat;
                cnt[ch] <= beats;
                ovf[ch] <= ovf[ch] | carry;
            end
        end
    end

    // Scale stage register holding one completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_valid <= 1'b0;
            sc_sum   <= '0;
            sc_ch    <= '0;
            sc_cnt   <= '0;
            sc_sat   <= 1'b0;
        end else begin
            sc_valid <= frame_done;
            if (frame_done) begin
                sc_sum <= sum_sat;
                sc_ch  <= ch;
                sc_cnt <= beats;
                sc_sat <= ovf[ch] | carry;
            end
        end
    end

    // Shift and clamp use the config values present while the frame sits in the scale stage.
    always_comb begin
        shifted = sc_sum >> bus.cfg_shift;
        clip    = |shifted[ACC_W-1:DATAWIDTH_OUT];
        if (clip) begin
            out_val = '1;
        end else if (shifted[DATAWIDTH_OUT-1:0] < bus.cfg_min) begin
            out_val = bus.cfg_min;
        end else begin
            out_val = shifted[DATAWIDTH_OUT-1:0];
        end
        wentry = '{dout: out_val, tuser: sc_ch, cnt: sc_cnt, sat: sc_sat | clip};
    end

    assign pop = bus.dout_tvalid & bus.dout_tready;

    accum_frame_mc_out_fifo u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (sc_valid),
        .wdata (wentry),
        .pop   (pop),
        .rdata (rentry),
        .count (fifo_count)
    );

    assign bus.dout_tvalid = (fifo_count != '0);
    assign bus.dout        = rentry.dout;
    assign bus.dout_tuser  = rentry.tuser;
    assign bus.dout_cnt    = rentry.cnt;
    assign bus.dout_sat    = rentry.sat;

    // Next-cycle occupancy counts the frame entering the scale stage, so no result can overrun the queue.
    assign occ_next = (PTR_W+2)'(fifo_count) + (PTR_W+2)'(sc_valid)
                    + (PTR_W+2)'(frame_done) - (PTR_W+2)'(pop);

    // Input ready is registered from the projected occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.din_tready <= 1'b0;
        end else begin
            bus.din_tready <= (occ_next < (PTR_W+2)'(OUT_DEPTH));
        end
    end

endmodule

// File: tb/tb_accum_frame_mc.sv
// tb/tb_accum_frame_mc.sv - randomized self-checking bench for accum_frame_mc
module tb_accum_frame_mc;

    logic clk;
    logic rst_n;
    accum_frame_mc_if bus();

    accum_frame_mc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint      m_sum [4];
    int          m_cnt [4];
    logic [21:0] expq [$];
    int          cur_shift;
    int          cur_min;

    function automatic logic [21:0] model_frame(input longint sum, input int ch, input int nbeats);
        longint s;
        int     d;
        bit     sat;
        s   = sum >>> cur_shift;
        sat = 1'b0;
        if (s > 255) begin
            d   = 255;
            sat = 1'b1;
        end else if (s < cur_min) begin
            d = cur_min;
        end else begin
            d = int'(s);
        end
        if (nbeats > 2047) nbeats = 2047;
        return {8'(d), 2'(ch), 11'(nbeats), sat};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic set_cfg(input int sh, input int mn);
        cur_shift     = sh;
        cur_min       = mn;
        bus.cfg_shift = 6'(sh);
        bus.cfg_min   = 8'(mn);
    endtask

    task automatic send_beat(input int ch, input longint d, input bit last);
        int n;
        n = 0;
        @(negedge clk);
        bus.din        = 32'(d);
        bus.din_tuser  = 2'(ch);
        bus.din_tlast  = last;
        bus.din_tvalid = 1'b1;
        while (!bus.din_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.din_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout din_tready=%0b required=1", bus.din_tready);
            bus.din_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.din_tvalid = 1'b0;
        bus.din_tlast  = 1'b0;
        if (last) begin
            expq.push_back(model_frame(m_sum[ch] + d, ch, m_cnt[ch] + 1));
            m_sum[ch] = 0;
            m_cnt[ch] = 0;
        end else begin
            m_sum[ch] += d;
            m_cnt[ch]++;
        end
    endtask

    task automatic recv(output logic [21:0] got, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.dout_tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok  = bus.dout_tvalid;
        got = {bus.dout, bus.dout_tuser, bus.dout_cnt, bus.dout_sat};
        if (ok) begin
            bus.dout_tready = 1'b1;
            @(posedge clk);
            #1;
            bus.dout_tready = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        expq.delete();
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {bus.dout, bus.dout_tuser, bus.dout_cnt, bus.dout_sat};
        checks++;
        if (bus.dout_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_tvalid got=%0b required=0", bus.dout_tvalid);
        end
        checks++;
        if (obs !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0", obs);
        end
        checks++;
        if (bus.din_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready_low got=%0b required=0", bus.din_tready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        expq.delete();
        @(posedge clk);
        #1;
        checks++;
        if (bus.din_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready_release got=%0b required=1", bus.din_tready);
        end
    endtask

    task automatic test_basic_latency();
        logic [21:0] got;
        logic [21:0] exp;
        bit ok;
        set_cfg(20, 1);
        for (int i = 0; i < 4; i++) send_beat(0, 64'h0010_0000, i == 3);
        checks++;
        if (bus.dout_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got=%0b required=0", bus.dout_tvalid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.dout_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL latency_n2 got=%0b required=1", bus.dout_tvalid);
        end
        recv(got, ok);
        exp = expq.pop_front();
        checks++;
        if (!ok || got !== exp || exp !== {8'd4, 2'd0, 11'd4, 1'b0}) begin
            errors++;
            $display("FAIL basic_ch0 got=%h required=%h valid=%0b", got, exp, ok);
        end
    endtask

    task automatic test_min_and_sat();
        logic [21:0] got;
        logic [21:0] exp;
        bit ok;
        set_cfg(20, 1);
        send_beat(1, 0, 1'b1);
        send_beat(1, 64'h2000_0000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            recv(got, ok);
            exp = expq.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL min_sat_%0d got=%h required=%h valid=%0b", i, got, exp, ok);
            end
        end
    endtask

    task automatic test_interleave();
        int tab_ch [8] = '{1, 2, 1, 2, 1, 2, 2, 1};
        int tab_d  [8] = '{1, 2, 3, 4, 5, 6, 8, 7};
        bit tab_l  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
        logic [21:0] got;
        logic [21:0] exp;
        bit ok;
        set_cfg(0, 1);
        for (int i = 0; i < 8; i++) send_beat(tab_ch[i], tab_d[i], tab_l[i]);
        for (int i = 0; i < 2; i++) begin
            recv(got, ok);
            exp = expq.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL interleave_%0d got=%h required=%h valid=%0b", i, got, exp, ok);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [21:0] got;
        logic [21:0] exp;
        bit ok;
        set_cfg(0, 0);
        for (int i = 0; i < 4; i++) send_beat($urandom_range(0, 3), $urandom_range(0, 255), 1'b1);
        checks++;
        if (bus.din_tready !== 1'b0) begin
            errors++;
            $display("FAIL bp_tready_after4 got=%0b required=0", bus.din_tready);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.din_tready !== 1'b0 || bus.dout_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got=%0b%0b required=01", bus.din_tready, bus.dout_tvalid);
        end
        fork
            begin
                for (int i = 0; i < 2; i++) send_beat($urandom_range(0, 3), $urandom_range(0, 255), 1'b1);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    recv(got, ok);
                    exp = (expq.size() != 0) ? expq.pop_front() : 22'h3fffff;
                    checks++;
                    if (!ok || got !== exp) begin
                        errors++;
                        $display("FAIL bp_order_%0d got=%h required=%h valid=%0b", i, got, exp, ok);
                    end
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        logic [21:0] got;
        logic [21:0] exp;
        bit ok;
        set_cfg(0, 1);
        send_beat(0, 5, 1'b1);
        send_beat(0, 7, 1'b1);
        for (int i = 0; i < 2; i++) begin
            recv(got, ok);
            exp = expq.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL b2b_%0d got=%h required=%h valid=%0b", i, got, exp, ok);
            end
        end
        send_beat(0, 100, 1'b0);
        send_beat(0, 200, 1'b0);
        pulse_reset();
        @(posedge clk);
        #1;
        checks++;
        if (bus.dout_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_tvalid got=%0b required=0", bus.dout_tvalid);
        end
        set_cfg(0, 1);
        send_beat(0, 3, 1'b1);
        recv(got, ok);
        exp = expq.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL midreset_frame got=%h required=%h valid=%0b", got, exp, ok);
        end
    endtask

    task automatic test_soft_clr();
        logic [21:0] got;
        logic [21:0] exp;
        bit ok;
        set_cfg(0, 1);
        for (int i = 0; i < 3; i++) send_beat(3, 10, 1'b0);
        @(negedge clk);
        bus.din        = 32'd99;
        bus.din_tuser  = 2'd3;
        bus.din_tlast  = 1'b0;
        bus.din_tvalid = 1'b1;
        bus.soft_clr   = 1'b1;
        @(posedge clk);
        #1;
        bus.din_tvalid = 1'b0;
        bus.soft_clr   = 1'b0;
        model_clear();
        send_beat(3, 2, 1'b1);
        recv(got, ok);
        exp = expq.pop_front();
        checks++;
        if (!ok || got !== exp || exp !== {8'd2, 2'd3, 11'd1, 1'b0}) begin
            errors++;
            $display("FAIL soft_clr got=%h required=%h valid=%0b", got, exp, ok);
        end
    endtask

    task automatic test_random();
        logic [21:0] got;
        logic [21:0] exp;
        bit ok;
        int lasts;
        for (int r = 0; r < 20; r++) begin
            set_cfg($urandom_range(0, 24), $urandom_range(0, 6));
            lasts = 0;
            for (int b = 0; b < 8 && lasts < 3; b++) begin
                bit l;
                longint d;
                l = ($urandom_range(0, 2) == 0);
                d = ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom_range(0, 5000));
                send_beat($urandom_range(0, 3), d, l);
                if (l) lasts++;
            end
            while (expq.size() != 0) begin
                recv(got, ok);
                exp = expq.pop_front();
                checks++;
                if (!ok || got !== exp) begin
                    errors++;
                    $display("FAIL random_r%0d got=%h required=%h valid=%0b", r, got, exp, ok);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b1;
        bus.din         = '0;
        bus.din_tvalid  = 1'b0;
        bus.din_tlast   = 1'b0;
        bus.din_tuser   = '0;
        bus.cfg_shift   = '0;
        bus.cfg_min     = 8'd1;
        bus.soft_clr    = 1'b0;
        bus.dout_tready = 1'b0;
        cur_shift       = 0;
        cur_min         = 1;
        model_clear();
        test_reset();
        test_basic_latency();
        test_min_and_sat();
        test_interleave();
        test_backpressure();
        test_back_to_back();
        test_soft_clr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
